// File: rtl/note_highway_pkg.sv
// Shared types, constants and helpers for the note_highway lane engine.
// Optional feature macro: NOTE_HIGHWAY_COMBO_MULT_EN (combo score multiplier).
package note_highway_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    JudgeNone,
    JudgeHit,
    JudgeMiss
  } judge_e;

  // Streak length per multiplier tier
  localparam int unsigned COMBO_STEP = 8;

`ifdef NOTE_HIGHWAY_COMBO_MULT_EN
  localparam int unsigned MAX_MULT = 4;
`else
  localparam int unsigned MAX_MULT = 1;
`endif

  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

  // Only valid for v <= 99
  function automatic logic [7:0] bin_to_bcd2(input logic [7:0] v);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = v / 8'd10;
    ones = v - (tens * 8'd10);
    return {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/note_highway_if.sv
// Game-side bus of note_highway: step strobe, pattern RAM port, keys and display outputs.
interface note_highway_if #(
  parameter int unsigned NUM_TRACKS   = 4,
  parameter int unsigned LANE_DEPTH   = 8,
  parameter int unsigned LOAD_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned SCORE_DIGITS = 4
);
  logic                               step;
  logic [ADDR_WIDTH-1:0]              pattern_addr;
  logic [NUM_TRACKS*LOAD_WIDTH-1:0]   pattern_data;
  logic [NUM_TRACKS-1:0]              keys_n;
  logic [NUM_TRACKS*LANE_DEPTH-1:0]   lane_bits;
  logic [NUM_TRACKS-1:0]              strike_row;
  logic [4*SCORE_DIGITS-1:0]          score_bcd;
  logic [7:0]                         combo;
  logic                               hit_pulse;
  logic                               miss_pulse;
  logic                               song_done;

  // Engine side
  modport slave (
    input  step, pattern_data, keys_n,
    output pattern_addr, lane_bits, strike_row, score_bcd, combo,
    output hit_pulse, miss_pulse, song_done
  );

  // Game controller / display side
  modport master (
    output step, pattern_data, keys_n,
    input  pattern_addr, lane_bits, strike_row, score_bcd, combo,
    input  hit_pulse, miss_pulse, song_done
  );
endinterface

// File: rtl/note_highway_bcd_score_counter.sv
// Saturating BCD accumulator: adds a 2-digit BCD value when enabled, clamps at all-9s.
module bcd_score_counter
  import note_highway_pkg::*;
#(
  parameter int unsigned SCORE_DIGITS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [7:0]                i_add_bcd,
  output logic [4*SCORE_DIGITS-1:0] o_score
);
  localparam int unsigned PadDigits = (SCORE_DIGITS > 2) ? SCORE_DIGITS : 2;

  logic [4*SCORE_DIGITS-1:0] r_score;
  logic [4*SCORE_DIGITS-1:0] w_sum;
  logic [4*SCORE_DIGITS-1:0] w_next;
  logic [4*PadDigits-1:0]    w_add_pad;
  logic [4:0]                w_dsum;
  logic                      w_carry;
  logic                      w_add_hi;
  logic                      w_ovf;

  // Addend digits that do not fit the score width count as overflow
  if (PadDigits > SCORE_DIGITS) begin : g_narrow
    assign w_add_hi = |w_add_pad[4*PadDigits-1:4*SCORE_DIGITS];
  end else begin : g_wide
    assign w_add_hi = 1'b0;
  end

  // Digit-serial BCD ripple add with saturation on final carry
  always_comb begin
    w_add_pad = (4*PadDigits)'(i_add_bcd);
    w_carry   = 1'b0;
    w_dsum    = '0;
    w_sum     = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      w_dsum = {1'b0, r_score[i*4 +: 4]} + {1'b0, w_add_pad[i*4 +: 4]} + {4'd0, w_carry};
      if (w_dsum > 5'd9) begin
        w_sum[i*4 +: 4] = 4'(w_dsum - 5'd10);
        w_carry         = 1'b1;
      end else begin
        w_sum[i*4 +: 4] = w_dsum[3:0];
        w_carry         = 1'b0;
      end
    end
    w_ovf  = w_carry | w_add_hi;
    w_next = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      w_next[i*4 +: 4] = w_ovf ? bcd_digit_t'(4'd9) : w_sum[i*4 +: 4];
    end
  end

  // Score register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_score <= '0;
    end else if (i_en) begin
      r_score <= w_next;
    end
  end

  assign o_score = r_score;

endmodule

// File: rtl/note_highway.sv
// Note-lane engine: falling-note lanes refilled from pattern RAM, strike-row judgement,
// combo streak, BCD score and end-of-song flag.
// Optional feature macro: NOTE_HIGHWAY_COMBO_MULT_EN (score multiplier grows with combo).
module note_highway
  import note_highway_pkg::*;
#(
  parameter int unsigned NUM_TRACKS   = 4,
  parameter int unsigned LANE_DEPTH   = 8,
  parameter int unsigned LOAD_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned SONG_LEN     = 128,
  parameter int unsigned SCORE_DIGITS = 4
) (
  input logic          CLOCK_50,
  input logic          RESET_GAME,
  note_highway_if.slave bus
);
  localparam int unsigned PhW = (LOAD_WIDTH > 1) ? $clog2(LOAD_WIDTH) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(LOAD_WIDTH - 1);
  // Address is one bit wider so SONG_LEN == 2**ADDR_WIDTH is still reachable
  localparam logic [ADDR_WIDTH:0] SongEnd = (ADDR_WIDTH + 1)'(SONG_LEN);

  if (NUM_TRACKS * MAX_MULT > 99) begin : g_chk_mult
    $error("NUM_TRACKS * MAX_MULT must not exceed 99");
  end
  if (NUM_TRACKS > 32) begin : g_chk_tracks
    $error("NUM_TRACKS must not exceed 32");
  end
  if (LANE_DEPTH < 2) begin : g_chk_depth
    $error("LANE_DEPTH must be at least 2");
  end
  if (SONG_LEN > (1 << ADDR_WIDTH)) begin : g_chk_len
    $error("SONG_LEN must fit the pattern address space");
  end

  logic [NUM_TRACKS*LANE_DEPTH-1:0] r_lane;
  logic [NUM_TRACKS*LANE_DEPTH-1:0] w_lane_d;
  logic [NUM_TRACKS*LOAD_WIDTH-1:0] r_stage;
  logic [NUM_TRACKS*LOAD_WIDTH-1:0] w_stage_d;
  logic [PhW-1:0]                   r_phase;
  logic [PhW-1:0]                   w_phase_d;
  logic [ADDR_WIDTH:0]              r_addr;
  logic [ADDR_WIDTH:0]              w_addr_d;
  logic [NUM_TRACKS-1:0]            r_key_meta;
  logic [NUM_TRACKS-1:0]            r_key_sync;
  logic [7:0]                       r_combo;
  logic                             r_hit;
  logic                             r_miss;
  logic                             r_done;

  logic                             w_load;
  logic                             w_fetch;
  logic                             w_done_cond;
  logic [NUM_TRACKS-1:0]            w_strike;
  logic [NUM_TRACKS-1:0]            w_pressed;
  judge_e                           w_judge;
  logic [7:0]                       w_mult;
  logic [7:0]                       w_add_bin;
  logic [7:0]                       w_add_bcd;
  logic [4*SCORE_DIGITS-1:0]        w_score;
`ifdef NOTE_HIGHWAY_COMBO_MULT_EN
  logic [7:0]                       w_tier;
`endif

  // Lane shift, staging refill and pattern fetch for the next step
  always_comb begin
    w_load    = (r_phase == PhLast);
    w_fetch   = w_load && (r_addr < SongEnd);
    w_addr_d  = w_fetch ? r_addr + 1'b1 : r_addr;
    w_phase_d = w_load ? '0 : r_phase + 1'b1;
    w_lane_d  = '0;
    w_stage_d = '0;
    w_strike  = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      w_strike[t] = r_lane[t*LANE_DEPTH];
      w_lane_d[t*LANE_DEPTH +: LANE_DEPTH] =
          {r_stage[t*LOAD_WIDTH + LOAD_WIDTH - 1], r_lane[t*LANE_DEPTH + 1 +: LANE_DEPTH - 1]};
      if (w_load) begin
        w_stage_d[t*LOAD_WIDTH +: LOAD_WIDTH] =
            w_fetch ? bus.pattern_data[t*LOAD_WIDTH +: LOAD_WIDTH] : '0;
      end else begin
        w_stage_d[t*LOAD_WIDTH +: LOAD_WIDTH] = r_stage[t*LOAD_WIDTH +: LOAD_WIDTH] << 1;
      end
    end
    w_done_cond = (w_addr_d == SongEnd) && (w_lane_d == '0) && (w_stage_d == '0);
  end

  // Judge the strike row as it stands before this step's shift
  always_comb begin
    w_pressed = ~r_key_sync;
    w_judge   = JudgeNone;
    if (!r_done) begin
      if (w_pressed != w_strike) begin
        w_judge = JudgeMiss;
      end else if (w_strike != '0) begin
        w_judge = JudgeHit;
      end
    end
`ifdef NOTE_HIGHWAY_COMBO_MULT_EN
    w_tier = r_combo / 8'(COMBO_STEP);
    w_mult = (w_tier > 8'(MAX_MULT - 1)) ? 8'(MAX_MULT) : w_tier + 8'd1;
`else
    w_mult = 8'd1;
`endif
    w_add_bin = popcount(32'(w_strike)) * w_mult;
    w_add_bcd = bin_to_bcd2(w_add_bin);
  end

  // Game state: key synchroniser, lanes, fetch pointer, streak, pulses, end flag
  always_ff @(posedge CLOCK_50) begin
    if (RESET_GAME) begin
      r_key_meta <= '1;
      r_key_sync <= '1;
      r_lane     <= '0;
      r_stage    <= '0;
      r_phase    <= PhLast;
      r_addr     <= '0;
      r_combo    <= '0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_key_meta <= bus.keys_n;
      r_key_sync <= r_key_meta;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      if (bus.step) begin
        r_lane  <= w_lane_d;
        r_stage <= w_stage_d;
        r_phase <= w_phase_d;
        r_addr  <= w_addr_d;
        r_hit   <= (w_judge == JudgeHit);
        r_miss  <= (w_judge == JudgeMiss);
        if (w_judge == JudgeHit) begin
          if (r_combo != 8'hFF) begin
            r_combo <= r_combo + 8'd1;
          end
        end else if (w_judge == JudgeMiss) begin
          r_combo <= '0;
        end
        if (w_done_cond) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  bcd_score_counter #(
    .SCORE_DIGITS(SCORE_DIGITS)
  ) u_score (
    .i_clk    (CLOCK_50),
    .i_rst    (RESET_GAME),
    .i_en     (bus.step && (w_judge == JudgeHit)),
    .i_add_bcd(w_add_bcd),
    .o_score  (w_score)
  );

  assign bus.pattern_addr = r_addr[ADDR_WIDTH-1:0];
  assign bus.lane_bits    = r_lane;
  assign bus.strike_row   = w_strike;
  assign bus.score_bcd    = w_score;
  assign bus.combo        = r_combo;
  assign bus.hit_pulse    = r_hit;
  assign bus.miss_pulse   = r_miss;
  assign bus.song_done    = r_done;

endmodule

// File: doc/note_highway.md
# note_highway

Parametrised note-lane engine for the Guitar Hero game: N tracks, each a LANE_DEPTH-deep falling-note shift register, refilled from a synchronous pattern RAM in LOAD_WIDTH-bit words. On every game step it judges the bottom row against the player keys, keeps a combo streak and a saturating BCD score, and flags end of song. It sits between the RAM tracks/RDF game-tick divider and the HEX/VGA display logic, replacing the per-track shifter chains and the scoreboard.

## Interface
- NUM_TRACKS, 4, number of lanes/keys
- LANE_DEPTH, 8, visible rows per lane (row 0 = strike row)
- LOAD_WIDTH, 4, bits per track per pattern word (rows per RAM load)
- ADDR_WIDTH, 7, pattern RAM address width
- SONG_LEN, 128, number of pattern words in the song (≤ 2^ADDR_WIDTH)
- SCORE_DIGITS, 4, BCD score digits

- CLOCK_50  in  1  system clock
- RESET_GAME  in  1  synchronous, active-high reset
- step  in  1  one-cycle game-tick strobe; min spacing 2 cycles
- pattern_addr  out  ADDR_WIDTH  pattern RAM address
- pattern_data  in  NUM_TRACKS*LOAD_WIDTH  RAM q, valid 1 cycle after address change; track t in slice [t*LW +: LW], MSB = first row to fall
- keys_n  in  NUM_TRACKS  active-low buttons, asynchronous
- lane_bits  out  NUM_TRACKS*LANE_DEPTH  lane contents for VGA, track t in [t*LD +: LD]
- strike_row  out  NUM_TRACKS  lane bit 0 of every track
- score_bcd  out  4*SCORE_DIGITS  BCD score, digit 0 in [3:0]
- combo  out  8  current streak, saturates at 255
- hit_pulse  out  1  one-cycle, correct judgement
- miss_pulse  out  1  one-cycle, wrong judgement
- song_done  out  1  sticky end-of-song flag

## Operation
- Reset values: all lanes 0, staging 0, phase = LOAD_WIDTH-1, pattern_addr 0, score 0, combo 0, pulses 0, song_done 0; key synchroniser cleared to "not pressed".
- keys_n passes through 2-flop synchroniser; pressed = ~keys_sync.
- Per step, per track: lane <= {staging[LW-1], lane[LD-1:1]}; if phase == LW-1 then staging <= load slice, phase <= 0, else staging <= staging<<1, phase++.
- Load slice = pattern_data slice while pattern_addr < SONG_LEN, then pattern_addr increments; once pattern_addr == SONG_LEN, load slice = 0 and address holds.
- Judgement uses strike_row before the shift (same step cycle):
  - strike_row ≠ 0 and pressed == strike_row: hit; score += popcount(strike_row) × mult; combo sat-increment.
  - strike_row ≠ 0 and pressed ≠ strike_row: miss; combo <= 0.
  - strike_row == 0 and pressed ≠ 0: miss (stray press); combo <= 0.
  - both zero: no event.
- Score add is BCD ripple addition; on overflow past all-9s, score saturates at all-9s.
- song_done set on the step where pattern_addr == SONG_LEN and all staging and lane bits are 0 after the shift; once set, judgement disabled, lanes keep shifting zeros.
- step asserted with RESET_GAME: reset wins, step ignored.

## Timing
- All outputs registered. lane_bits, strike_row, pattern_addr, score_bcd, combo, hit/miss_pulse update on the clock edge closing the step cycle (visible step+1).
- Key-to-judgement latency 2 cycles (synchroniser).
- pattern_data sampled on step cycle; address changes at step+1, data valid by step+2, hence ≥2-cycle step spacing.
- First note row of word 0 reaches row 0 after LW+LD steps from reset... precisely: word 0 MSB enters lane on step 2, reaches strike_row after step 2+LD-1.

## Configuration
- NOTE_HIGHWAY_COMBO_MULT_EN defined: mult = 1 + min(combo/8, 3) using combo before the update (1..4).
- Undefined: mult = 1; combo still counted and output.
- Constraint (elaborated check): NUM_TRACKS × max mult ≤ 99.

## Structure
- Package note_highway_pkg: BCD digit typedef, MAX_MULT, COMBO_STEP (8), popcount function, binary-to-2-digit-BCD function.
- Sub-module bcd_score_counter: SCORE_DIGITS-wide saturating BCD accumulator with add-value input and enable; lanes and judgement stay in the top.

## Test plan
- Reset then 2 steps with word 0 = track0 4'b1000: lane_bits track0 = 8'b1000_0000, pattern_addr = 1.
- Single note on track1 at strike row, keys_n = 4'b1101 held: hit_pulse, score 0001, combo 1.
- Strike row 4'b0101, only track0 pressed: miss_pulse, combo 0, score unchanged.
- Empty strike row, key pressed: miss_pulse; no keys: no pulse.
- With macro, 8 consecutive 2-note hits then one more: 9th adds 4 (combo 8 → mult 2); without macro adds 2.
- Score preloaded 9998, 4-note hit: score 9999 saturated; SONG_LEN=2 run: song_done set exactly when last row leaves lane, RESET_GAME mid-song clears all.
